mem_access: RTL and testbench
=============================

Name:
mem_access

Overview:
Memory stage of the RV32 core, directly downstream of the execute stage via the exe_mem register. It turns execute's memory operation (op, address, store data) into one data-bus transaction with byte enables. For loads it aligns and sign/zero-extends the returned data. It passes non-memory results through to writeback and stalls the pipeline while a transaction is outstanding.

Parameters:
- DATA_WIDTH, 32: data path width; only 32 is supported.
- ADDR_WIDTH, 32: address width.
- TIMEOUT_CYCLES, 255: maximum number of BUSY cycles without dbus_ack_i before the access is aborted; must be ≥1.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
reg_waddr_i  in  5  destination register, from exe_mem
reg_we_i  in  1  register write enable, from exe_mem
reg_wdata_i  in  32  ALU result, from exe_mem
mem_op_i  in  4  memory op: NOP=0 LB=1 LH=2 LW=3 LBU=4 LHU=5 SB=6 SH=7 SW=8 (MEM_* in defines.v); 9–15 treated as NOP
mem_addr_i  in  32  byte address
mem_data_i  in  32  store data (low byte/half/word used)
dbus_req_o  out  1  bus request
dbus_we_o  out  1  1=write
dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dbus_be_o  out  4  byte enables
dbus_wdata_o  out  32  lane-replicated store data
dbus_ack_i  in  1  transaction complete; read data valid in same cycle
dbus_rdata_i  in  32  read word
reg_waddr_o  out  5  to mem_wb
reg_we_o  out  1  to mem_wb
reg_wdata_o  out  32  to mem_wb
stall_o  out  1  to hdu; freezes pc..exe_mem
bus_err_o  out  1  one-cycle pulse on timeout
misalign_o  out  1  one-cycle pulse on misaligned access (tied 0 when feature is off)

Behaviour:
- Reset: state=IDLE, counter=0. Every registered output is 0: dbus_*, bus_err_o, misalign_o. Reset wins over all events, including an ack in the same cycle. On reset mid-BUSY, dbus_req_o drops at the next edge and any late ack is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE, op=NOP: combinational pass-through. reg_*_o = reg_*_i; stall_o=0; stay in IDLE.
- IDLE, memory op: stall_o=1 combinationally and writeback outputs are driven 0. At the next edge:
  - register dbus_addr/we/be/wdata, clear the counter, go to BUSY.
- BUSY:
  - dbus_req_o=1 (Moore). All bus outputs are held stable. stall_o=1.
  - On dbus_ack_i: capture rdata, go to DONE.
  - On no ack: counter increments. When counter==TIMEOUT_CYCLES-1 and there is still no ack, go to DONE flagged as error. Req is therefore held exactly TIMEOUT_CYCLES cycles.
  - Ack on the timeout cycle: the ack wins and no error is raised.
- DONE:
  - stall_o=0; reg_waddr_o=reg_waddr_i.
  - Load: reg_we_o=reg_we_i, reg_wdata_o=extended data.
  - Store: reg_we_o=0.
  - Error: reg_we_o=0, bus_err_o=1.
  - Next state IDLE. The pipeline advances at the end of the DONE cycle, so the IDLE cycle after it sees a new instruction; hdu guarantees this.
- Minimum latency is 3 cycles per memory op (detect, BUSY with immediate ack, DONE). Back-to-back memory ops add no extra bubble.
- Byte enables and store data:
  - SB: be=1<<addr[1:0], wdata={4{d[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata={2{d[15:0]}}.
  - SW: be=1111, wdata=d.
  - Loads use the same be pattern with dbus_we_o=0.
- Load extraction:
  - LB/LBU take byte lane addr[1:0].
  - LH/LHU take half-word lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- dbus_ack_i in IDLE or DONE is ignored.

Optional Feature:
MEM_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, is misaligned.
  - A misaligned access issues no bus request: IDLE goes directly to DONE.
  - In that DONE cycle misalign_o=1 and reg_we_o=0.
- Undefined:
  - misalign_o=0 always.
  - Offending low address bits are ignored: the half-word uses addr[1], the word uses lane 0.

Test Plan:
- LB addr=0x1003, ack after 2 BUSY cycles, rdata=0x80123456 → dbus_addr=0x1000, be=1000, reg_wdata=0xFFFFFF80 in DONE, stall_o high 3 cycles. LBU with the same stimulus → 0x00000080.
- SH addr=0x2002, data=0x1234BEEF, immediate ack → be=1100, wdata=0xBEEFBEEF, we=1, reg_we_o=0 in DONE.
- ADD result 0x55 to x5 with op=NOP → reg_wdata_o=0x55, reg_we_o=1 the same cycle, stall_o=0, dbus_req_o never asserted.
- TIMEOUT_CYCLES=4, LW 0x3000, no ack → req high exactly 4 cycles, then DONE with bus_err_o=1, reg_we_o=0. Repeat with ack on the 4th cycle → bus_err_o=0 and data written.
- rst_i asserted in the 2nd BUSY cycle, ack arrives one cycle later → req=0 after the edge, state IDLE, no writeback, ack ignored.
- LW 0x1001: with MEM_MISALIGN_TRAP_EN → misalign_o pulse, no req. Without it → req with addr=0x1000, be=1111.

Source files
------------

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Brief    : RV32 memory stage; one data-bus transaction per load/store with
//            byte enables, load alignment/extension and pipeline stall.
//            Optional macro MEM_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [DATA_WIDTH-1:0] reg_wdata_i,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [ADDR_WIDTH-1:0] dbus_addr_o,
    output logic [3:0]            dbus_be_o,
    output logic [DATA_WIDTH-1:0] dbus_wdata_o,
    input  logic                  dbus_ack_i,
    input  logic [DATA_WIDTH-1:0] dbus_rdata_i,
    output logic [4:0]            reg_waddr_o,
    output logic                  reg_we_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  stall_o,
    output logic                  bus_err_o,
    output logic                  misalign_o
);

    localparam logic [3:0] c_op_lb  = 4'd1;
    localparam logic [3:0] c_op_lh  = 4'd2;
    localparam logic [3:0] c_op_lw  = 4'd3;
    localparam logic [3:0] c_op_lbu = 4'd4;
    localparam logic [3:0] c_op_lhu = 4'd5;
    localparam logic [3:0] c_op_sb  = 4'd6;
    localparam logic [3:0] c_op_sh  = 4'd7;
    localparam logic [3:0] c_op_sw  = 4'd8;

    localparam int                 c_CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_count;
    logic [3:0]           r_op;
    logic [1:0]           r_lane;
    logic [31:0]          r_rdata;

    logic                 w_is_load;
    logic                 w_is_store;
    logic                 w_misalign;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic                 w_issue;
    logic                 w_trap;
    logic                 w_timeout;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_load_data;
    logic                 w_done_load;

    assign w_is_load  = (mem_op_i >= c_op_lb) && (mem_op_i <= c_op_lhu);
    assign w_is_store = (mem_op_i >= c_op_sb) && (mem_op_i <= c_op_sw);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = (((mem_op_i == c_op_lh) || (mem_op_i == c_op_lhu) || (mem_op_i == c_op_sh))
                         && mem_addr_i[0])
                     || (((mem_op_i == c_op_lw) || (mem_op_i == c_op_sw))
                         && (mem_addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Lane selection ignores low address bits that do not fit the access size.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = mem_data_i;
        case (mem_op_i)
            c_op_lb, c_op_lbu, c_op_sb: begin
                w_be    = 4'b0001 << mem_addr_i[1:0];
                w_wdata = {4{mem_data_i[7:0]}};
            end
            c_op_lh, c_op_lhu, c_op_sh: begin
                w_be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_data_i[15:0]}};
            end
            c_op_lw, c_op_sw: w_be = 4'b1111;
            default:          w_be = 4'b0000;
        endcase
    end

    assign w_byte = r_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = r_lane[1] ? r_rdata[31:16] : r_rdata[15:0];

    always_comb begin
        w_load_data = 32'h0;
        w_done_load = 1'b1;
        case (r_op)
            c_op_lb:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: w_load_data = {24'h0, w_byte};
            c_op_lh:  w_load_data = {{16{w_half[15]}}, w_half};
            c_op_lhu: w_load_data = {16'h0, w_half};
            c_op_lw:  w_load_data = r_rdata;
            default:  w_done_load = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_trap       = 1'b0;
        w_timeout    = 1'b0;
        stall_o      = 1'b0;
        reg_waddr_o  = 5'd0;
        reg_we_o     = 1'b0;
        reg_wdata_o  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_is_load || w_is_store) begin
                    stall_o = 1'b1;
                    if (w_misalign) begin
                        w_trap       = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_issue      = 1'b1;
                        w_state_next = S_BUSY;
                    end
                end else begin
                    reg_waddr_o = reg_waddr_i;
                    reg_we_o    = reg_we_i;
                    reg_wdata_o = reg_wdata_i;
                end
            end
            S_BUSY: begin
                stall_o = 1'b1;
                if (dbus_ack_i) begin
                    w_state_next = S_DONE;
                end else if (r_count == c_CNT_MAX) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                reg_waddr_o  = reg_waddr_i;
                if (w_done_load && !bus_err_o && !misalign_o) begin
                    reg_we_o    = reg_we_i;
                    reg_wdata_o = w_load_data;
                end
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_op         <= 4'd0;
            r_lane       <= 2'd0;
            r_rdata      <= 32'h0;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= 4'b0000;
            dbus_wdata_o <= '0;
            bus_err_o    <= 1'b0;
            misalign_o   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            bus_err_o  <= w_timeout;
            misalign_o <= w_trap;
            if (r_state == S_IDLE) begin
                r_op   <= mem_op_i;
                r_lane <= mem_addr_i[1:0];
            end
            if (w_issue) begin
                dbus_req_o   <= 1'b1;
                dbus_we_o    <= w_is_store;
                dbus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                dbus_be_o    <= w_be;
                dbus_wdata_o <= w_wdata;
                r_count      <= '0;
            end
            if (r_state == S_BUSY) begin
                if (dbus_ack_i) begin
                    r_rdata    <= dbus_rdata_i;
                    dbus_req_o <= 1'b0;
                end else if (w_timeout) begin
                    dbus_req_o <= 1'b0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Brief    : Self-checking bench for mem_access (TIMEOUT_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        stall_o;
    logic        bus_err_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .reg_waddr_i (reg_waddr_i),
        .reg_we_i    (reg_we_i),
        .reg_wdata_i (reg_wdata_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .dbus_req_o  (dbus_req_o),
        .dbus_we_o   (dbus_we_o),
        .dbus_addr_o (dbus_addr_o),
        .dbus_be_o   (dbus_be_o),
        .dbus_wdata_o(dbus_wdata_o),
        .dbus_ack_i  (dbus_ack_i),
        .dbus_rdata_i(dbus_rdata_i),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o),
        .reg_wdata_o (reg_wdata_o),
        .stall_o     (stall_o),
        .bus_err_o   (bus_err_o),
        .misalign_o  (misalign_o)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ack_at;     // 0-based BUSY cycle carrying ack; >=4 means none
        logic [31:0] bus_addr;
        logic [3:0]  be;
        logic        bus_we;
        logic [31:0] bus_wdata;  // compared for stores only
        logic        wb_we;
        logic [31:0] wb_data;    // compared when wb_we is expected
        int          busy;
        logic        err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Entered at #1 after a rising edge with the DUT in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        int  n;
        bit  done;
        reg_waddr_i  = 5'(idx + 1);
        reg_we_i     = 1'b1;
        reg_wdata_i  = 32'hDEAD0000;
        mem_op_i     = v.op;
        mem_addr_i   = v.addr;
        mem_data_i   = v.sdata;
        dbus_rdata_i = v.rdata;
        dbus_ack_i   = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d detect_stall", idx), 32'(stall_o), 32'd1);
        chk($sformatf("v%0d detect_wb_we", idx), 32'(reg_we_o), 32'd0);
        chk($sformatf("v%0d detect_req", idx), 32'(dbus_req_o), 32'd0);
        chk($sformatf("v%0d detect_err_clear", idx), 32'(bus_err_o), 32'd0);
        n    = 0;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk);
            #1 dbus_ack_i = 1'b0;
            @(negedge clk);
            if (dbus_req_o) begin
                n++;
                chk($sformatf("v%0d busy%0d_stall", idx, n), 32'(stall_o), 32'd1);
                chk($sformatf("v%0d busy%0d_addr", idx, n), dbus_addr_o, v.bus_addr);
                chk($sformatf("v%0d busy%0d_be", idx, n), 32'(dbus_be_o), 32'(v.be));
                chk($sformatf("v%0d busy%0d_we", idx, n), 32'(dbus_we_o), 32'(v.bus_we));
                if (v.bus_we)
                    chk($sformatf("v%0d busy%0d_wdata", idx, n), dbus_wdata_o, v.bus_wdata);
                if (n == v.ack_at + 1)
                    dbus_ack_i = 1'b1;
            end else begin
                done = 1;
            end
        end
        if (!done)
            chk($sformatf("v%0d req_never_dropped", idx), 32'd0, 32'd1);
        chk($sformatf("v%0d busy_cycles", idx), 32'(n), 32'(v.busy));
        chk($sformatf("v%0d done_stall", idx), 32'(stall_o), 32'd0);
        chk($sformatf("v%0d done_bus_err", idx), 32'(bus_err_o), 32'(v.err));
        chk($sformatf("v%0d done_misalign", idx), 32'(misalign_o), 32'd0);
        chk($sformatf("v%0d done_waddr", idx), 32'(reg_waddr_o), 32'(idx + 1));
        chk($sformatf("v%0d done_wb_we", idx), 32'(reg_we_o), 32'(v.wb_we));
        if (v.wb_we)
            chk($sformatf("v%0d done_wb_data", idx), reg_wdata_o, v.wb_data);
        @(posedge clk);
        #1 dbus_ack_i = 1'b0;
    endtask

    initial begin
        //        op    addr          sdata         rdata         ack  bus_addr      be       we    bus_wdata     wbwe  wb_data       busy err
        vecs[0]  = '{4'd1, 32'h00001003, 32'h0,        32'h80123456, 1,  32'h00001000, 4'b1000, 1'b0, 32'h0,        1'b1, 32'hFFFFFF80, 2, 1'b0};
        vecs[1]  = '{4'd4, 32'h00001003, 32'h0,        32'h80123456, 1,  32'h00001000, 4'b1000, 1'b0, 32'h0,        1'b1, 32'h00000080, 2, 1'b0};
        vecs[2]  = '{4'd7, 32'h00002002, 32'h1234BEEF, 32'h0,        0,  32'h00002000, 4'b1100, 1'b1, 32'hBEEFBEEF, 1'b0, 32'h0,        1, 1'b0};
        vecs[3]  = '{4'd3, 32'h00003000, 32'h0,        32'hFFFFFFFF, 99, 32'h00003000, 4'b1111, 1'b0, 32'h0,        1'b0, 32'h0,        4, 1'b1};
        vecs[4]  = '{4'd3, 32'h00003000, 32'h0,        32'hCAFEF00D, 3,  32'h00003000, 4'b1111, 1'b0, 32'h0,        1'b1, 32'hCAFEF00D, 4, 1'b0};
        vecs[5]  = '{4'd2, 32'h00000006, 32'h0,        32'h80017FFF, 0,  32'h00000004, 4'b1100, 1'b0, 32'h0,        1'b1, 32'hFFFF8001, 1, 1'b0};
        vecs[6]  = '{4'd5, 32'h00000004, 32'h0,        32'h1234ABCD, 1,  32'h00000004, 4'b0011, 1'b0, 32'h0,        1'b1, 32'h0000ABCD, 2, 1'b0};
        vecs[7]  = '{4'd1, 32'h00000001, 32'h0,        32'h000071FF, 0,  32'h00000000, 4'b0010, 1'b0, 32'h0,        1'b1, 32'h00000071, 1, 1'b0};
        vecs[8]  = '{4'd6, 32'h00000102, 32'h000000A5, 32'h0,        0,  32'h00000100, 4'b0100, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,        1, 1'b0};
        vecs[9]  = '{4'd8, 32'h00000FFC, 32'h89ABCDEF, 32'h0,        2,  32'h00000FFC, 4'b1111, 1'b1, 32'h89ABCDEF, 1'b0, 32'h0,        3, 1'b0};
        vecs[10] = '{4'd1, 32'h00000002, 32'h0,        32'h00FE0000, 0,  32'h00000000, 4'b0100, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFE, 1, 1'b0};

        rst_i        = 1'b1;
        reg_waddr_i  = 5'd0;
        reg_we_i     = 1'b0;
        reg_wdata_i  = 32'h0;
        mem_op_i     = 4'd0;
        mem_addr_i   = 32'h0;
        mem_data_i   = 32'h0;
        dbus_ack_i   = 1'b1;
        dbus_rdata_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req", 32'(dbus_req_o), 32'd0);
        chk("reset_we", 32'(dbus_we_o), 32'd0);
        chk("reset_addr", dbus_addr_o, 32'd0);
        chk("reset_be", 32'(dbus_be_o), 32'd0);
        chk("reset_wdata", dbus_wdata_o, 32'd0);
        chk("reset_bus_err", 32'(bus_err_o), 32'd0);
        chk("reset_misalign", 32'(misalign_o), 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;

        // Pass-through of a non-memory result, including an out-of-range op code.
        for (int i = 0; i < 2; i++) begin
            mem_op_i    = (i == 0) ? 4'd0 : 4'd9;
            reg_waddr_i = 5'd5;
            reg_we_i    = 1'b1;
            reg_wdata_i = 32'h55 + 32'(i);
            @(negedge clk);
            chk($sformatf("nop%0d wb_data", i), reg_wdata_o, 32'h55 + 32'(i));
            chk($sformatf("nop%0d wb_we", i), 32'(reg_we_o), 32'd1);
            chk($sformatf("nop%0d wb_waddr", i), 32'(reg_waddr_o), 32'd5);
            chk($sformatf("nop%0d stall", i), 32'(stall_o), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("nop%0d req", i), 32'(dbus_req_o), 32'd0);
            @(posedge clk);
            #1;
        end
        dbus_ack_i = 1'b0;

        for (int i = 0; i < 11; i++)
            run_vec(vecs[i], i);

        // Reset during the second BUSY cycle, with a late ack after it.
        reg_waddr_i = 5'd7;
        reg_we_i    = 1'b0;
        mem_op_i    = 4'd3;
        mem_addr_i  = 32'h00003000;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy1_req", 32'(dbus_req_o), 32'd1);
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        chk("rst_busy2_req", 32'(dbus_req_o), 32'd1);
        @(posedge clk);
        #1 begin
            rst_i        = 1'b0;
            dbus_ack_i   = 1'b1;
            dbus_rdata_i = 32'h12345678;
            mem_op_i     = 4'd0;
        end
        @(negedge clk);
        chk("rst_after_req", 32'(dbus_req_o), 32'd0);
        chk("rst_after_stall", 32'(stall_o), 32'd0);
        chk("rst_after_wb_we", 32'(reg_we_o), 32'd0);
        @(posedge clk);
        #1 dbus_ack_i = 1'b0;
        @(negedge clk);
        chk("rst_late_ack_req", 32'(dbus_req_o), 32'd0);
        chk("rst_late_ack_err", 32'(bus_err_o), 32'd0);
        chk("rst_late_ack_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;

        // Misaligned LW at 0x1001.
`ifdef MEM_MISALIGN_TRAP_EN
        reg_waddr_i = 5'd9;
        reg_we_i    = 1'b1;
        mem_op_i    = 4'd3;
        mem_addr_i  = 32'h00001001;
        @(negedge clk);
        chk("mis_detect_stall", 32'(stall_o), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mis_done_flag", 32'(misalign_o), 32'd1);
        chk("mis_done_req", 32'(dbus_req_o), 32'd0);
        chk("mis_done_wb_we", 32'(reg_we_o), 32'd0);
        chk("mis_done_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1 mem_op_i = 4'd0;
        @(negedge clk);
        chk("mis_idle_flag", 32'(misalign_o), 32'd0);
        chk("mis_idle_req", 32'(dbus_req_o), 32'd0);
        @(posedge clk);
        #1;
`else
        begin
            vec_t mv;
            mv = '{4'd3, 32'h00001001, 32'h0, 32'h11223344, 0, 32'h00001000, 4'b1111, 1'b0,
                   32'h0, 1'b1, 32'h11223344, 1, 1'b0};
            run_vec(mv, 20);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
